// File: rtl/exu_pkg.sv
// Shared Execute-stage definitions: operand width, divider opcodes and FSM states.
// Also holds the conditional two's-complement helper used for sign fixup.
package exu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state_t;

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift the next dividend bit in, trial-subtract, keep or restore.
module div_step
  import exu_pkg::*;
(
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] q,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] q_next
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          fits;

  // rem < divisor on entry, so the shifted value fits in XLEN+1 bits and the
  // borrow out of the wide subtraction is an exact "shifted < divisor" flag.
  assign shifted  = {rem, q[XLEN-1]};
  assign diff     = shifted - {1'b0, divisor};
  assign fits     = ~diff[XLEN];
  assign rem_next = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  assign q_next   = {q[XLEN-2:0], fits};

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 DIV/DIVU/REM/REMU unit: one restoring step per cycle, single-cycle done pulse.
// Divide-by-zero and signed overflow are resolved at the accept edge without iterating.
module div_unit
  import exu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [1:0]      div_op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int              CNT_W   = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t       state, state_next;
  logic [CNT_W-1:0] count;

  logic [XLEN-1:0] rem, q, divisor;
  logic [XLEN-1:0] rem_step, q_step;
  logic            is_rem, quot_neg, rem_neg;

  logic            op_signed, op_rem, a_neg, b_neg;
  logic            b_zero, ovf, special, accept, last_step, finish;
  logic [XLEN-1:0] a_abs, b_abs, special_res, final_res;

  assign op_signed = (div_op == DIV) || (div_op == REM);
  assign op_rem    = (div_op == REM) || (div_op == REMU);
  assign a_neg     = op_signed && a[XLEN-1];
  assign b_neg     = op_signed && b[XLEN-1];
  assign a_abs     = neg_if(a, a_neg);
  assign b_abs     = neg_if(b, b_neg);

  assign b_zero      = (b == '0);
  assign ovf         = op_signed && (a == MIN_NEG) && (b == '1);
  assign special     = b_zero || ovf;
  assign special_res = b_zero ? (op_rem ? a : '1) : (op_rem ? '0 : MIN_NEG);

  assign accept    = (state == IDLE) && start && !flush;
  assign last_step = (count == CNT_W'(XLEN - 1));
  assign finish    = (state == CALC) && last_step && !flush;

  div_step u_step (
    .rem      (rem),
    .q        (q),
    .divisor  (divisor),
    .rem_next (rem_step),
    .q_next   (q_step)
  );

  // Sign fixup is applied to the outputs of the final step so the result lands on that edge.
  assign final_res = is_rem ? neg_if(rem_step, rem_neg) : neg_if(q_step, quot_neg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    done       = 1'b0;
    case (state)
      IDLE: if (accept) state_next = special ? DONE : CALC;
      CALC: begin
        if (flush)          state_next = IDLE;
        else if (last_step) state_next = DONE;
      end
      DONE: begin
        done       = !flush;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      result <= '0;
    end else begin
      if (accept)              count <= '0;
      else if (state == CALC)  count <= count + CNT_W'(1);
      if (accept && special)   result <= special_res;
      else if (finish)         result <= final_res;
    end
  end

  // Operand and iteration registers carry no reset; they are always loaded on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      rem      <= '0;
      q        <= a_abs;
      divisor  <= b_abs;
      is_rem   <= op_rem;
      quot_neg <= a_neg ^ b_neg;
      rem_neg  <= a_neg;
    end else if (state == CALC) begin
      rem <= rem_step;
      q   <= q_step;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases, randomized ops against an arithmetic model,
// start/flush/reset interactions and back-to-back operations.
module tb_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [1:0]  div_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  div_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .flush  (flush),
    .div_op (div_op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: RISC-V M-extension divide semantics in plain arithmetic.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
    logic sgn;
    logic isrem;
    int   sx;
    int   sy;
    sgn   = (op == 2'b00) || (op == 2'b10);
    isrem = (op == 2'b10) || (op == 2'b11);
    if (y == 32'd0) return isrem ? x : 32'hFFFF_FFFF;
    if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return isrem ? 32'd0 : 32'h8000_0000;
    if (sgn) begin
      sx = x;
      sy = y;
      return isrem ? 32'(sx % sy) : 32'(sx / sy);
    end
    return isrem ? (x % y) : (x / y);
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
    logic sgn;
    sgn = (op == 2'b00) || (op == 2'b10);
    if (y == 32'd0) return 0;
    if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 0;
    return 32;
  endfunction

  // Starts one op from IDLE, scrambles operands after accept, and returns at the negedge where done is seen.
  // lat counts rising edges after the accept edge.
  task automatic run_op(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output int lat, output bit ok);
    @(negedge clk);
    start = 1'b1; div_op = op; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; div_op = 2'($urandom_range(0, 3));
    lat = 0; ok = 1'b0; res = 32'hx;
    while (lat < 100) begin
      if (done) begin ok = 1'b1; res = result; break; end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", result); end
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned;
    logic [31:0] r; int lat; bit ok;
    run_op(2'b01, 32'd100, 32'd7, r, lat, ok);
    checks++; if (!ok || r !== 32'd14) begin errors++; $display("FAIL divu_100_7: got %h expected 0000000e", r); end
    checks++; if (lat !== 32) begin errors++; $display("FAIL divu_latency: got %0d expected 32", lat); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_in_done: got %b expected 1", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL after_done: got busy=%b done=%b expected 0 0", busy, done); end
    checks++; if (result !== 32'd14) begin errors++; $display("FAIL result_hold: got %h expected 0000000e", result); end
    run_op(2'b11, 32'd100, 32'd7, r, lat, ok);
    checks++; if (!ok || r !== 32'd2) begin errors++; $display("FAIL remu_100_7: got %h expected 00000002", r); end
  endtask

  task automatic test_signed;
    logic [1:0]  ops [5] = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b10};
    logic [31:0] xs  [5] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7, 32'hFFFF_FFF9};
    logic [31:0] ys  [5] = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
    logic [31:0] exp [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
    logic [31:0] r; int lat; bit ok;
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], xs[i], ys[i], r, lat, ok);
      checks++; if (!ok || r !== exp[i]) begin errors++; $display("FAIL signed_%0d: got %h expected %h", i, r, exp[i]); end
    end
  endtask

  task automatic test_special;
    logic [31:0] r; int lat; bit ok;
    run_op(2'b00, 32'h1234, 32'd0, r, lat, ok);
    checks++; if (!ok || r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_by_zero: got %h expected ffffffff", r); end
    checks++; if (lat !== 0) begin errors++; $display("FAIL div0_latency: got %0d expected 0", lat); end
    run_op(2'b11, 32'h1234, 32'd0, r, lat, ok);
    checks++; if (!ok || r !== 32'h1234) begin errors++; $display("FAIL remu_by_zero: got %h expected 00001234", r); end
    run_op(2'b10, 32'hFFFF_FF00, 32'd0, r, lat, ok);
    checks++; if (!ok || r !== 32'hFFFF_FF00) begin errors++; $display("FAIL rem_by_zero: got %h expected ffffff00", r); end
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, ok);
    checks++; if (!ok || r !== 32'h8000_0000) begin errors++; $display("FAIL div_overflow: got %h expected 80000000", r); end
    checks++; if (lat !== 0) begin errors++; $display("FAIL ovf_latency: got %0d expected 0", lat); end
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, ok);
    checks++; if (!ok || r !== 32'd0) begin errors++; $display("FAIL rem_overflow: got %h expected 00000000", r); end
    run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, ok);
    checks++; if (!ok || r !== model(2'b01, 32'h8000_0000, 32'hFFFF_FFFF)) begin errors++; $display("FAIL divu_min_by_ones: got %h expected %h", r, model(2'b01, 32'h8000_0000, 32'hFFFF_FFFF)); end
    checks++; if (lat !== 32) begin errors++; $display("FAIL divu_no_special: got %0d expected 32", lat); end
    run_op(2'b01, 32'hFFFF_FFFF, 32'h8000_0000, r, lat, ok);
    checks++; if (!ok || r !== 32'd1) begin errors++; $display("FAIL divu_ones_by_min: got %h expected 00000001", r); end
  endtask

  task automatic test_random;
    logic [1:0]  op; logic [31:0] x, y, r; int lat; bit ok; int sel;
    for (int i = 0; i < 48; i++) begin
      op  = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 7);
      x   = $urandom;
      y   = $urandom;
      if (sel == 0) y = 32'd0;
      else if (sel == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
      else if (sel == 2) y = 32'($urandom_range(1, 15));
      else if (sel == 3) y = -32'($urandom_range(1, 15));
      run_op(op, x, y, r, lat, ok);
      checks++; if (!ok || r !== model(op, x, y)) begin errors++; $display("FAIL random_%0d op=%0d a=%h b=%h: got %h expected %h", i, op, x, y, r, model(op, x, y)); end
      checks++; if (lat !== model_lat(op, x, y)) begin errors++; $display("FAIL random_lat_%0d: got %0d expected %0d", i, lat, model_lat(op, x, y)); end
    end
  endtask

  task automatic test_start_ignored;
    int lat; bit seen;
    @(negedge clk);
    start = 1'b1; div_op = 2'b01; a = 32'd1000; b = 32'd10;
    @(negedge clk);
    lat = 0;
    while (lat < 100 && !done) begin
      if (lat == 9) begin start = 1'b1; div_op = 2'b00; a = 32'd77; b = 32'd7; end
      else start = 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    checks++; if (done !== 1'b1 || result !== 32'd100) begin errors++; $display("FAIL start_while_busy: got %h expected 00000064", result); end
    checks++; if (lat !== 32) begin errors++; $display("FAIL restart_latency: got %0d expected 32", lat); end
    start = 1'b1; div_op = 2'b01; a = 32'd50; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_in_done: got busy=%b expected 0", busy); end
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (done) seen = 1'b1; end
    checks++; if (seen) begin errors++; $display("FAIL start_in_done_done: got done expected none"); end
  endtask

  task automatic test_flush;
    logic [31:0] r, prev; int lat; bit ok, seen;
    run_op(2'b01, 32'd500, 32'd5, prev, lat, ok);
    checks++; if (!ok || prev !== 32'd100) begin errors++; $display("FAIL pre_flush: got %h expected 00000064", prev); end
    @(negedge clk);
    start = 1'b1; div_op = 2'b01; a = 32'h0000_FFFF; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL flush_calc: got busy=%b done=%b expected 0 0", busy, done); end
    checks++; if (result !== prev) begin errors++; $display("FAIL flush_result: got %h expected %h", result, prev); end
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (done) seen = 1'b1; end
    checks++; if (seen) begin errors++; $display("FAIL flush_no_done: got done expected none"); end
    flush = 1'b1; start = 1'b1; div_op = 2'b01; a = 32'd9; b = 32'd3;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle_start: got busy=%b expected 0", busy); end
    run_op(2'b01, 32'd81, 32'd9, r, lat, ok);
    flush = 1'b1;
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL flush_done_cycle: got done=%b expected 0", done); end
    @(negedge clk);
    flush = 1'b0;
    checks++; if (busy !== 1'b0 || result !== 32'd9) begin errors++; $display("FAIL flush_done_after: got busy=%b result=%h expected 0 00000009", busy, result); end
  endtask

  task automatic test_reset_midop;
    logic [31:0] r; int lat; bit ok;
    @(negedge clk);
    start = 1'b1; div_op = 2'b01; a = 32'hFFFF_FFFF; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_midop_ctl: got busy=%b done=%b expected 0 0", busy, done); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_midop_result: got %h expected 00000000", result); end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(2'b01, 32'd9, 32'd3, r, lat, ok);
    checks++; if (!ok || r !== 32'd3) begin errors++; $display("FAIL post_reset_divu: got %h expected 00000003", r); end
    checks++; if (lat !== 32) begin errors++; $display("FAIL post_reset_latency: got %0d expected 32", lat); end
  endtask

  task automatic test_back_to_back;
    logic [1:0]  ops [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b11};
    logic [31:0] xs  [6] = '{32'hFFFF_FC18, 32'd12345, 32'd100, 32'hDEAD_BEEF, 32'h7FFF_FFFF, 32'd5};
    logic [31:0] ys  [6] = '{32'd10, 32'd0, 32'hFFFF_FFF9, 32'd16, 32'hFFFF_FFFF, 32'd9};
    logic [31:0] r; int lat; bit ok;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], xs[i], ys[i], r, lat, ok);
      checks++; if (!ok || r !== model(ops[i], xs[i], ys[i])) begin errors++; $display("FAIL b2b_%0d: got %h expected %h", i, r, model(ops[i], xs[i], ys[i])); end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; div_op = 2'b00; a = '0; b = '0;
    test_reset;
    test_unsigned;
    test_signed;
    test_special;
    test_random;
    test_start_ignored;
    test_flush;
    test_reset_midop;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
